// File: rtl/clock_pkg.sv
// Shared constants and time-of-day record for the digital clock controller.
package clock_pkg;

    localparam int SEC_MAX     = 59;
    localparam int MIN_MAX     = 59;
    localparam int HOUR_MAX    = 23;
    localparam int HOUR12_NOON = 12;

    // Default field width; the top module re-declares the same layout at its own W.
    localparam int TIME_W = 8;

    typedef struct packed {
        logic [TIME_W-1:0] hour;
        logic [TIME_W-1:0] minute;
        logic [TIME_W-1:0] sec;
    } time_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-second tick; freezes while run=0.
module tick_prescaler #(
    parameter int CLK_DIV = 4,
    parameter int DIV_W   = $clog2(CLK_DIV + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == DIV_W'(CLK_DIV - 1));
    assign tick   = run && w_wrap && !clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= w_wrap ? '0 : r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/digital_clock_ctrl.sv
// HH:MM:SS timekeeper with prescaler, checked load, 12-hour view, carry strobes and alarm.
module digital_clock_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int W       = 8,
    parameter int DIV_W   = $clog2(CLK_DIV + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         run,
    input  logic         load,
    input  logic [W-1:0] load_hour,
    input  logic [W-1:0] load_min,
    input  logic [W-1:0] load_sec,
    input  logic         alarm_en,
    input  logic [W-1:0] alarm_hour,
    input  logic [W-1:0] alarm_min,
    output logic [W-1:0] sec,
    output logic [W-1:0] minute,
    output logic [W-1:0] hour,
    output logic [W-1:0] hour12,
    output logic         pm,
    output logic         sec_tick,
    output logic         min_tick,
    output logic         hour_tick,
    output logic         day_tick,
    output logic         alarm_hit,
    output logic         load_err
);

    typedef struct packed {
        logic [W-1:0] hour;
        logic [W-1:0] minute;
        logic [W-1:0] sec;
    } hms_t;

    localparam logic [W-1:0] L_SEC_MAX  = W'(SEC_MAX);
    localparam logic [W-1:0] L_MIN_MAX  = W'(MIN_MAX);
    localparam logic [W-1:0] L_HOUR_MAX = W'(HOUR_MAX);
    localparam logic [W-1:0] L_NOON     = W'(HOUR12_NOON);

    hms_t         r_time;
    logic [W-1:0] r_hour12;
    logic         r_pm;
    logic         r_sec_tick, r_min_tick, r_hour_tick, r_day_tick;
    logic         r_alarm_hit, r_load_err;

    hms_t         w_nxt;
    logic [W-1:0] w_hour12;
    logic         w_tick, w_load_ok;
    logic         w_sec_tick, w_min_tick, w_hour_tick, w_day_tick;
    logic         w_alarm_hit, w_load_err;

    assign w_load_ok = (load_hour <= L_HOUR_MAX) && (load_min <= L_MIN_MAX) &&
                       (load_sec <= L_SEC_MAX);

    // Any load freezes the prescaler; only an accepted one restarts the second.
    tick_prescaler #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (run && !load),
        .clear (load && w_load_ok),
        .tick  (w_tick)
    );

    always_comb begin
        w_nxt       = r_time;
        w_sec_tick  = 1'b0;
        w_min_tick  = 1'b0;
        w_hour_tick = 1'b0;
        w_day_tick  = 1'b0;
        if (load) begin
            if (w_load_ok) begin
                w_nxt.hour   = load_hour;
                w_nxt.minute = load_min;
                w_nxt.sec    = load_sec;
            end
        end else if (w_tick) begin
            w_sec_tick = 1'b1;
            if (r_time.sec == L_SEC_MAX) begin
                w_nxt.sec  = '0;
                w_min_tick = 1'b1;
                if (r_time.minute == L_MIN_MAX) begin
                    w_nxt.minute = '0;
                    w_hour_tick  = 1'b1;
                    if (r_time.hour == L_HOUR_MAX) begin
                        w_nxt.hour = '0;
                        w_day_tick = 1'b1;
                    end else begin
                        w_nxt.hour = r_time.hour + W'(1);
                    end
                end else begin
                    w_nxt.minute = r_time.minute + W'(1);
                end
            end else begin
                w_nxt.sec = r_time.sec + W'(1);
            end
        end

        w_load_err  = load && !w_load_ok;
        w_alarm_hit = w_tick && !load && alarm_en && (w_nxt.sec == '0) &&
                      (w_nxt.minute == alarm_min) && (w_nxt.hour == alarm_hour);

        if (w_nxt.hour == '0) begin
            w_hour12 = L_NOON;
        end else if (w_nxt.hour > L_NOON) begin
            w_hour12 = w_nxt.hour - L_NOON;
        end else begin
            w_hour12 = w_nxt.hour;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_time      <= '0;
            r_hour12    <= L_NOON;
            r_pm        <= 1'b0;
            r_sec_tick  <= 1'b0;
            r_min_tick  <= 1'b0;
            r_hour_tick <= 1'b0;
            r_day_tick  <= 1'b0;
            r_alarm_hit <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_time      <= w_nxt;
            r_hour12    <= w_hour12;
            r_pm        <= (w_nxt.hour >= L_NOON);
            r_sec_tick  <= w_sec_tick;
            r_min_tick  <= w_min_tick;
            r_hour_tick <= w_hour_tick;
            r_day_tick  <= w_day_tick;
            r_alarm_hit <= w_alarm_hit;
            r_load_err  <= w_load_err;
        end
    end

    assign sec       = r_time.sec;
    assign minute    = r_time.minute;
    assign hour      = r_time.hour;
    assign hour12    = r_hour12;
    assign pm        = r_pm;
    assign sec_tick  = r_sec_tick;
    assign min_tick  = r_min_tick;
    assign hour_tick = r_hour_tick;
    assign day_tick  = r_day_tick;
    assign alarm_hit = r_alarm_hit;
    assign load_err  = r_load_err;

endmodule

// File: tb/tb_digital_clock_ctrl.sv
// Directed bench for digital_clock_ctrl at CLK_DIV=4, W=8; outputs sampled on the falling edge.
module tb_digital_clock_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         run;
    logic         load;
    logic [W-1:0] load_hour, load_min, load_sec;
    logic         alarm_en;
    logic [W-1:0] alarm_hour, alarm_min;
    logic [W-1:0] sec, minute, hour, hour12;
    logic         pm, sec_tick, min_tick, hour_tick, day_tick, alarm_hit, load_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt;

    digital_clock_ctrl #(.CLK_DIV(4), .W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .load       (load),
        .load_hour  (load_hour),
        .load_min   (load_min),
        .load_sec   (load_sec),
        .alarm_en   (alarm_en),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .sec        (sec),
        .minute     (minute),
        .hour       (hour),
        .hour12     (hour12),
        .pm         (pm),
        .sec_tick   (sec_tick),
        .min_tick   (min_tick),
        .hour_tick  (hour_tick),
        .day_tick   (day_tick),
        .alarm_hit  (alarm_hit),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle load pulse; the loaded values are visible at the following falling edge.
    task automatic do_load(input int h, input int m, input int s);
        load      = 1'b1;
        load_hour = W'(h);
        load_min  = W'(m);
        load_sec  = W'(s);
        cyc(1);
        load = 1'b0;
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, ".hour"}, 32'(hour), 32'(h));
        check({tag, ".min"},  32'(minute), 32'(m));
        check({tag, ".sec"},  32'(sec), 32'(s));
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; load = 1'b0;
        load_hour = '0; load_min = '0; load_sec = '0;
        alarm_en = 1'b0; alarm_hour = '0; alarm_min = '0;
        cyc(2);
        check_time("rst", 0, 0, 0);
        check("rst.hour12", 32'(hour12), 12);
        check("rst.pm", 32'(pm), 0);
        check("rst.sec_tick", 32'(sec_tick), 0);
        check("rst.load_err", 32'(load_err), 0);

        // Free run: tick every 4th cycle
        reset = 1'b0; run = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            cyc(1);
            check($sformatf("run.sec_tick%0d", c), 32'(sec_tick), (c % 4 == 0) ? 1 : 0);
        end
        check("run.sec", 32'(sec), 3);

        // Asynchronous reset mid-second, between clock edges
        cyc(2);
        #1 reset = 1'b1;
        #1;
        check("arst.sec", 32'(sec), 0);
        check("arst.hour12", 32'(hour12), 12);
        cyc(1);
        reset = 1'b0;

        // Full-day rollover
        do_load(23, 59, 58);
        check_time("ld1", 23, 59, 58);
        check("ld1.sec_tick", 32'(sec_tick), 0);
        check("ld1.pm", 32'(pm), 1);
        cyc(4);
        check_time("roll59", 23, 59, 59);
        check("roll59.min_tick", 32'(min_tick), 0);
        cyc(4);
        check_time("roll0", 0, 0, 0);
        check("roll0.sec_tick", 32'(sec_tick), 1);
        check("roll0.min_tick", 32'(min_tick), 1);
        check("roll0.hour_tick", 32'(hour_tick), 1);
        check("roll0.day_tick", 32'(day_tick), 1);
        check("roll0.hour12", 32'(hour12), 12);
        check("roll0.pm", 32'(pm), 0);
        cyc(1);
        check("roll1.day_tick", 32'(day_tick), 0);

        // 12-hour view and range-checked load
        run = 1'b0;
        do_load(13, 5, 0);
        check_time("ld13", 13, 5, 0);
        check("ld13.hour12", 32'(hour12), 1);
        check("ld13.pm", 32'(pm), 1);
        do_load(12, 0, 0);
        check("ld12.hour12", 32'(hour12), 12);
        check("ld12.pm", 32'(pm), 1);
        check("ld12.load_err", 32'(load_err), 0);
        do_load(24, 0, 0);
        check("ld24.load_err", 32'(load_err), 1);
        check_time("ld24", 12, 0, 0);
        do_load(0, 0, 60);
        check("lds60.load_err", 32'(load_err), 1);
        check_time("lds60", 12, 0, 0);
        cyc(1);
        check("lderr.clear", 32'(load_err), 0);

        // Pause after 2 prescaler cycles, resume from the partial second
        do_load(0, 0, 0);
        run = 1'b1;
        cyc(2);
        run = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            cyc(1);
            if (sec_tick) cnt++;
        end
        check("pause.ticks", 32'(cnt), 0);
        check("pause.sec", 32'(sec), 0);
        run = 1'b1;
        cyc(1);
        check("resume1.sec_tick", 32'(sec_tick), 0);
        cyc(1);
        check("resume2.sec_tick", 32'(sec_tick), 1);
        check("resume2.sec", 32'(sec), 1);

        // Alarm at 07:30
        alarm_en = 1'b1; alarm_hour = 8'd7; alarm_min = 8'd30;
        do_load(7, 29, 59);
        cnt = 0;
        for (int c = 1; c <= 4; c++) begin
            cyc(1);
            if (alarm_hit) cnt++;
        end
        check("alarm.hit_now", 32'(alarm_hit), 1);
        check_time("alarm", 7, 30, 0);
        cyc(4);
        if (alarm_hit) cnt++;
        check("alarm.count", 32'(cnt), 1);
        check("alarm.sec", 32'(sec), 1);

        alarm_en = 1'b0;
        do_load(7, 29, 59);
        cnt = 0;
        for (int c = 1; c <= 6; c++) begin
            cyc(1);
            if (alarm_hit) cnt++;
        end
        check("alarm_off.count", 32'(cnt), 0);

        alarm_en = 1'b1;
        run = 1'b0;
        do_load(7, 30, 0);
        check("alarm_ld.hit", 32'(alarm_hit), 0);
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            cyc(1);
            if (alarm_hit) cnt++;
        end
        check("alarm_ld.count", 32'(cnt), 0);
        alarm_en = 1'b0;

        // Load collides with a tick: load wins and the prescaler restarts
        run = 1'b1;
        do_load(5, 5, 5);
        cyc(3);
        check("pre.sec_tick", 32'(sec_tick), 0);
        do_load(10, 0, 0);
        check_time("coll", 10, 0, 0);
        check("coll.sec_tick", 32'(sec_tick), 0);
        cnt = 0;
        for (int c = 1; c <= 3; c++) begin
            cyc(1);
            if (sec_tick) cnt++;
        end
        check("coll.early_ticks", 32'(cnt), 0);
        cyc(1);
        check("coll.tick4", 32'(sec_tick), 1);
        check_time("coll4", 10, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
